// File: rtl/pool_flat_unit_pkg.sv
// Shared constants, memory-select codes and pool FSM encoding
// for the CNN accelerator pooling/flatten stage.
package cnn_pkg;

    localparam int CNN_DATA_W = 20;
    localparam int CNN_FRAC_W = 4;
    localparam int CNN_AW     = 12;

    typedef enum logic [2:0] {
        CSEL_NONE = 3'b000,
        CSEL_L0_0 = 3'b001,
        CSEL_L0_1 = 3'b010,
        CSEL_L1_0 = 3'b011,
        CSEL_L1_1 = 3'b100,
        CSEL_L2   = 3'b101
    } csel_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_CAP,
        S_WL1,
        S_WL2,
        S_DONE
    } state_t;

endpackage

// File: rtl/pool_flat_unit_if.sv
// Controller handshake plus shared memory port of the pooling stage.
// master = pooling unit, slave = controller/memory side.
interface pool_flat_unit_if
    import cnn_pkg::*;
#(
    parameter int DW = CNN_DATA_W
) ();

    logic              start;
    logic              busy;
    logic              done;
    logic [2:0]        csel;
    logic              crd;
    logic [CNN_AW-1:0] caddr_rd;
    logic [DW-1:0]     cdata_rd;
    logic              cwr;
    logic [CNN_AW-1:0] caddr_wr;
    logic [DW-1:0]     cdata_wr;

    modport master (
        input  start, cdata_rd,
        output busy, done, csel, crd, caddr_rd,
        output cwr, caddr_wr, cdata_wr
    );

    modport slave (
        output start, cdata_rd,
        input  busy, done, csel, crd, caddr_rd,
        input  cwr, caddr_wr, cdata_wr
    );

endinterface

// File: rtl/pool_round_sat.sv
// Ceil-to-integer of an unsigned fixed-point word, saturating
// to the largest integer value on overflow.
module pool_round_sat #(
    parameter int DATA_W   = 20,
    parameter int FRAC_W   = 4,
    parameter bit ROUND_UP = 1'b1
) (
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam logic [DATA_W-1:0] LOW =
        DATA_W'((1 << FRAC_W) - 1);
    localparam logic [DATA_W-1:0] SAT = ~LOW;
    localparam logic [DATA_W:0] STEP =
        (DATA_W+1)'(1) << FRAC_W;

    logic [DATA_W:0] sum;

    assign sum = {1'b0, din & SAT} + STEP;

    always_comb begin
        dout = din;
        if (ROUND_UP && ((din & LOW) != '0)) begin
            if (sum[DATA_W]) dout = SAT;
            else             dout = sum[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/pool_flat_unit.sv
// 2x2 stride-2 max-pool with ceil rounding; writes each result
// to L1 (per channel) and interleaved into the flattened L2.
module pool_flat_unit
    import cnn_pkg::*;
#(
    parameter int DATA_W   = CNN_DATA_W,
    parameter int FRAC_W   = CNN_FRAC_W,
    parameter int IMG_W    = 64,
    parameter bit ROUND_UP = 1'b1
) (
    input logic            clk,
    input logic            reset,
    pool_flat_unit_if.master bus
);

    localparam int AW = CNN_AW;
    localparam int P  = IMG_W / 2;
    localparam int PW = $clog2(P);

    state_t state, state_nx;

    logic              ch;
    logic [PW-1:0]     r, c;
    logic [DATA_W-1:0] max_reg;
    logic [DATA_W-1:0] result;
    logic              last;
    logic [AW-1:0]     base, l1a, l2a;
    csel_t             rsel, wsel;

    assign last = ch && (r == PW'(P-1)) &&
                  (c == PW'(P-1));
    assign base = AW'({r, 1'b0}) * AW'(IMG_W) +
                  AW'({c, 1'b0});
    assign l1a  = AW'(r) * AW'(P) + AW'(c);
    assign l2a  = {l1a[AW-2:0], ch};
    assign rsel = ch ? CSEL_L0_1 : CSEL_L0_0;
    assign wsel = ch ? CSEL_L1_1 : CSEL_L1_0;

    pool_round_sat #(
        .DATA_W  (DATA_W),
        .FRAC_W  (FRAC_W),
        .ROUND_UP(ROUND_UP)
    ) u_round (
        .din (max_reg),
        .dout(result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (bus.start) state_nx = S_RD0;
            S_RD0:  state_nx = S_RD1;
            S_RD1:  state_nx = S_RD2;
            S_RD2:  state_nx = S_RD3;
            S_RD3:  state_nx = S_CAP;
            S_CAP:  state_nx = S_WL1;
            S_WL1:  state_nx = S_WL2;
            S_WL2:  state_nx = last ? S_DONE : S_RD0;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // read data lags its strobe by one cycle, hence RD1..CAP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch      <= 1'b0;
            r       <= '0;
            c       <= '0;
            max_reg <= '0;
        end else begin
            case (state)
                S_RD1: max_reg <= bus.cdata_rd;
                S_RD2, S_RD3, S_CAP:
                    if (bus.cdata_rd > max_reg)
                        max_reg <= bus.cdata_rd;
                S_WL2: begin
                    if (c == PW'(P-1)) begin
                        c <= '0;
                        if (r == PW'(P-1)) begin
                            r  <= '0;
                            ch <= ~ch;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                S_DONE: begin
                    ch      <= 1'b0;
                    r       <= '0;
                    c       <= '0;
                    max_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.csel     = CSEL_NONE;
        bus.crd      = 1'b0;
        bus.caddr_rd = '0;
        bus.cwr      = 1'b0;
        bus.caddr_wr = '0;
        bus.cdata_wr = '0;
        unique case (state)
            S_RD0, S_RD1, S_RD2, S_RD3: begin
                bus.busy = 1'b1;
                bus.crd  = 1'b1;
                bus.csel = rsel;
                unique case (state)
                    S_RD0: bus.caddr_rd = base;
                    S_RD1: bus.caddr_rd = base + AW'(1);
                    S_RD2: bus.caddr_rd = base + AW'(IMG_W);
                    default:
                        bus.caddr_rd = base + AW'(IMG_W + 1);
                endcase
            end
            S_CAP: bus.busy = 1'b1;
            S_WL1: begin
                bus.busy     = 1'b1;
                bus.cwr      = 1'b1;
                bus.csel     = wsel;
                bus.caddr_wr = l1a;
                bus.cdata_wr = result;
            end
            S_WL2: begin
                bus.busy     = 1'b1;
                bus.cwr      = 1'b1;
                bus.csel     = CSEL_L2;
                bus.caddr_wr = l2a;
                bus.cdata_wr = result;
            end
            S_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/pool_flat_unit.md
Name: pool_flat_unit

Overview:
- Layer-1/layer-2 stage of the CNN accelerator; runs after the conv/ReLU pass has filled L0_MEM0/L0_MEM1 (64x64, 20-bit each).
- Performs 2x2 stride-2 max-pooling per kernel channel and rounds the result up to an integer.
- Writes each pooled value twice: to L1_MEM0/L1_MEM1 (32x32) and interleaved into L2_MEM (2048 entries, flatten).
- Owns the shared memory port while busy; launched by the top-level controller with a start/done handshake.

Parameters:
- DATA_W, 20, data word width (fixed-point, FRAC_W fractional bits)
- FRAC_W, 4, fractional bits in the data word
- IMG_W, 64, conv-map side length; pooled side = IMG_W/2
- ROUND_UP, 1, 1 = ceil to integer after max; 0 = pass max through

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  level; sampled only in IDLE
- busy  out  1  high from first read cycle through last write cycle
- done  out  1  one-cycle pulse after the last write
- csel  out  3  memory select: 001 L0_MEM0, 010 L0_MEM1, 011 L1_MEM0, 100 L1_MEM1, 101 L2_MEM, 000 none
- crd  out  1  read strobe
- caddr_rd  out  12  read address
- cdata_rd  in  DATA_W  read data; valid in the cycle after the crd cycle
- cwr  out  1  write strobe
- caddr_wr  out  12  write address
- cdata_wr  out  DATA_W  write data

Behaviour:
- Interface decision: clock clk; reset is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; counters ch/r/c = 0; max_reg = 0.
- Reset mid-operation aborts immediately, with the same reset values; no partial-write cleanup.
- States: IDLE, RD0, RD1, RD2, RD3, CAP, WL1, WL2, DONE.
- All outputs are a function of state and counters only (Moore).
- IDLE: start=1 -> RD0 (busy rises in the next cycle); else stay.
- Pixel order: ch outer (0,1), then r (0..31), then c (0..31). Base address B = 2r*IMG_W + 2c.
- RD0..RD3: crd=1, csel=L0_ch (001 for ch0, 010 for ch1). caddr_rd = B, B+1, B+IMG_W, B+IMG_W+1 respectively.
- Read data capture: data for the read issued in state k is sampled at the end of the next state.
  - RD1 loads max_reg.
  - RD2, RD3 and CAP each keep the unsigned larger of max_reg and cdata_rd; on a tie, max_reg is kept.
  - CAP has crd=0 and cwr=0.
- Inputs are ReLU outputs, so all comparisons are unsigned.
- Rounding (ROUND_UP=1):
  - If max_reg[FRAC_W-1:0] != 0, result = (max_reg with low bits cleared) + 2^FRAC_W; else result = max_reg.
  - If the add overflows DATA_W, saturate to all-ones with low FRAC_W bits zero (0xFFFF0).
- WL1: cwr=1, csel = 011 (ch0) or 100 (ch1), caddr_wr = r*32+c, cdata_wr = result.
- WL2: cwr=1, csel=101, caddr_wr = 2*(r*32+c)+ch, cdata_wr = result.
- After WL2:
  - Advance c; on c wrap advance r; on r wrap advance ch.
  - Go to RD0, or go to DONE if ch=1, r=31, c=31 was just written.
- DONE: done=1 and busy=0 for one cycle, counters cleared, then IDLE.
- Per-pixel cost is 7 cycles; a full run is 2048*7 = 14336 busy cycles.
- crd and cwr are never high in the same cycle. csel=000 in IDLE, CAP and DONE.
- start while busy is ignored. start held high through DONE relaunches from IDLE on the following cycle.

Decomposition:
- Shared package (cnn_pkg):
  - csel codes (CSEL_NONE, CSEL_L0_0, CSEL_L0_1, CSEL_L1_0, CSEL_L1_1, CSEL_L2)
  - DATA_W / FRAC_W / address width constants
  - pool FSM state encoding
- One sub-module: pool_round_sat, combinational ceil-to-integer with saturation, parameterised by DATA_W/FRAC_W and unit-testable alone.

Test Plan:
- Max and round: L0_MEM0[0,1,64,65] = 0x00010, 0x00025, 0x00013, 0x00020, start -> WL1 writes L1_MEM0[0] = 0x00030; WL2 writes L2[0] = 0x00030.
- Exact integer and tie: all four reads = 0x00040 -> written 0x00040. Max 0xFFFF1 -> 0xFFFF0 (saturate). ROUND_UP=0 with 0x00025 -> 0x00025.
- Address walk: ch0 r0 c1 reads 2, 3, 66, 67, writes L1 addr 1 and L2 addr 2. ch1 r31 c31 reads 4030, 4031, 4094, 4095 with csel 010, writes L1_MEM1 addr 1023 and L2 addr 2047.
- Handshake/timing:
  - start pulse -> busy high the next cycle, exactly 14336 busy cycles, then done high one cycle with busy=0.
  - Exactly 8192 crd cycles and 4096 cwr cycles; crd and cwr are never both high.
- Full-image scoreboard: random L0 contents -> L1_MEM0/1 and L2 match a software max-pool/ceil/flatten model bit-exactly.
- Reset at the cycle-5000 mid-run -> all outputs 0 asynchronously; a restart produces correct full results; start pulsed while busy has no effect.
